weight_bram_sequencer: RTL

- Controls one single-port weight BRAM: 16-bit data, 5-bit address, 28 entries. The BRAM reads and writes on the falling edge of CLK and holds DO when EN=0.
- Two jobs, one at a time:
  - Load: accepts a stream of weights from the loader and writes them to the BRAM.
  - Fetch: reads all weights in address order and streams them to the neuron MAC over a valid/ready handshake with backpressure.
- One instance sits between each weight BRAM and its neuron datapath.

---
 rtl/weight_bram_sequencer.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/weight_bram_sequencer.sv
// Load/fetch controller for one single-port weight BRAM (falling-edge BRAM, rising-edge control).
// Optional WSEQ_STALL_CNT_EN adds STALL_CNT, counting fetch cycles stalled by W_READY=0.
module weight_bram_sequencer #(
  parameter int unsigned DEPTH = 28,
  parameter int unsigned AW    = 5,
  parameter int unsigned DW    = 16
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          LOAD_START,
  input  logic          FETCH_START,
  output logic          BUSY,
  output logic          DONE,
  input  logic          LD_VALID,
  output logic          LD_READY,
  input  logic [DW-1:0] LD_DATA,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_IDX,
  output logic          W_LAST,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO
`ifdef WSEQ_STALL_CNT_EN
  ,
  output logic [15:0]   STALL_CNT
`endif
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_LOAD  = 2'd1;
  localparam logic [1:0] ST_FETCH = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] wptr;
  logic [CW-1:0] rptr;
  logic          inflight;

  logic [DW-1:0] fifo_data [2];
  logic [AW-1:0] fifo_idx  [2];
  logic          fifo_last [2];
  logic          fifo_rd;
  logic          fifo_wr;
  logic [1:0]    fifo_count;

  logic       ld_xfer;
  logic       pop;
  logic       push;
  logic       issue;
  logic [1:0] occ;

  assign BUSY     = (state != ST_IDLE);
  assign LD_READY = (state == ST_LOAD) && (wptr < DEPTH_C);
  assign ld_xfer  = LD_VALID && LD_READY;

  assign W_VALID = (state == ST_FETCH) && (fifo_count != 2'd0);
  assign W_DATA  = fifo_data[fifo_rd];
  assign W_IDX   = fifo_idx[fifo_rd];
  assign W_LAST  = W_VALID && fifo_last[fifo_rd];

  assign pop  = W_VALID && W_READY;
  assign push = (state == ST_FETCH) && inflight;

  // occ never exceeds 2, so a pop this edge always frees room for one more read
  always_comb begin
    occ   = fifo_count + {1'b0, inflight};
    issue = (state == ST_FETCH) && (rptr < DEPTH_C) && (pop || (occ < 2'd2));
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state      <= ST_IDLE;
      wptr       <= '0;
      rptr       <= '0;
      inflight   <= 1'b0;
      fifo_rd    <= 1'b0;
      fifo_wr    <= 1'b0;
      fifo_count <= '0;
      DONE       <= 1'b0;
      BRAM_ADDR  <= '0;
      BRAM_DI    <= '0;
      BRAM_EN    <= 1'b0;
      BRAM_WE    <= 1'b0;
      for (int unsigned i = 0; i < 2; i++) begin
        fifo_data[i] <= '0;
        fifo_idx[i]  <= '0;
        fifo_last[i] <= 1'b0;
      end
    end else begin
      DONE <= 1'b0;
      case (state)
        ST_IDLE: begin
          BRAM_EN <= 1'b0;
          BRAM_WE <= 1'b0;
          if (LOAD_START) begin
            state <= ST_LOAD;
            wptr  <= '0;
          end else if (FETCH_START) begin
            // first read goes out immediately so data is valid one cycle later
            state     <= ST_FETCH;
            BRAM_EN   <= 1'b1;
            BRAM_ADDR <= '0;
            rptr      <= CW'(1);
            inflight  <= 1'b1;
          end
        end
        ST_LOAD: begin
          if (ld_xfer) begin
            BRAM_EN   <= 1'b1;
            BRAM_WE   <= 1'b1;
            BRAM_ADDR <= AW'(wptr);
            BRAM_DI   <= LD_DATA;
            wptr      <= wptr + CW'(1);
          end else begin
            BRAM_EN <= 1'b0;
            BRAM_WE <= 1'b0;
            if (wptr == DEPTH_C) begin
              DONE  <= 1'b1;
              state <= ST_IDLE;
              wptr  <= '0;
            end
          end
        end
        ST_FETCH: begin
          BRAM_WE <= 1'b0;
          if (pop && W_LAST) begin
            DONE       <= 1'b1;
            state      <= ST_IDLE;
            BRAM_EN    <= 1'b0;
            rptr       <= '0;
            inflight   <= 1'b0;
            fifo_rd    <= 1'b0;
            fifo_wr    <= 1'b0;
            fifo_count <= '0;
          end else begin
            BRAM_EN  <= issue;
            inflight <= issue;
            if (issue) begin
              BRAM_ADDR <= AW'(rptr);
              rptr      <= rptr + CW'(1);
            end
            // BRAM_ADDR still names the in-flight read at this edge
            if (push) begin
              fifo_data[fifo_wr] <= BRAM_DO;
              fifo_idx[fifo_wr]  <= BRAM_ADDR;
              fifo_last[fifo_wr] <= (BRAM_ADDR == LAST_IDX);
              fifo_wr            <= ~fifo_wr;
            end
            if (pop) fifo_rd <= ~fifo_rd;
            case ({push, pop})
              2'b10:   fifo_count <= fifo_count + 2'd1;
              2'b01:   fifo_count <= fifo_count - 2'd1;
              default: fifo_count <= fifo_count;
            endcase
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

`ifdef WSEQ_STALL_CNT_EN
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      STALL_CNT <= '0;
    end else if ((state == ST_IDLE) && !LOAD_START && FETCH_START) begin
      STALL_CNT <= '0;
    end else if (W_VALID && !W_READY && (STALL_CNT != 16'hFFFF)) begin
      STALL_CNT <= STALL_CNT + 16'd1;
    end
  end
`endif

endmodule
